// File: rtl/oled_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : oled_frame_writer
// Brief    : Scans a paged frame buffer and streams it over 4-wire SPI to an
//            SH1106-class OLED, including panel reset and init commands.
//            Define FRAME_AUTO_EN for continuous back-to-back frame refresh.
// Revision : 1.0 - initial release
// ============================================================================
module oled_frame_writer #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned RES_CYCLES = 1000,
    parameter int unsigned COLS       = 132,
    parameter int unsigned PAGES      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] ram_addr_x,
    output logic [7:0] ram_addr_y,
    input  logic [7:0] ram_data,
    output logic       busy,
    output logic       frame_done,
    output logic       oled_sclk,
    output logic       oled_mosi,
    output logic       oled_cs_n,
    output logic       oled_dc,
    output logic       oled_res_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]       LAST_COL  = 8'(COLS - 1);
    localparam logic [7:0]       LAST_PAGE = 8'(PAGES - 1);

    typedef enum logic [2:0] {
        S_RES_HOLD = 3'd0,
        S_INIT     = 3'd1,
        S_IDLE     = 3'd2,
        S_PAGE_CMD = 3'd3,
        S_FETCH    = 3'd4,
        S_DATA     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      res_cnt_q, res_cnt_d;
    logic             res_phase_q, res_phase_d;
    logic             res_n_q, res_n_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       page_q, page_d;
    logic [7:0]       col_q, col_d;
    logic             fetch_wait_q, fetch_wait_d;
    logic [7:0]       addr_x_q, addr_x_d;
    logic [7:0]       addr_y_q, addr_y_d;

    logic             tx_run_q, tx_run_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       shift_q, shift_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             dc_q, dc_d;

    logic             tx_start;
    logic [7:0]       tx_byte;
    logic             tx_dc;

    function automatic logic [7:0] init_byte(input logic [2:0] i);
        case (i)
            3'd0:    init_byte = 8'hAE;
            3'd1:    init_byte = 8'hA1;
            3'd2:    init_byte = 8'hC8;
            3'd3:    init_byte = 8'h81;
            3'd4:    init_byte = 8'h80;
            default: init_byte = 8'hAF;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        res_cnt_d    = res_cnt_q;
        res_phase_d  = res_phase_q;
        res_n_d      = res_n_q;
        idx_d        = idx_q;
        page_d       = page_q;
        col_d        = col_q;
        fetch_wait_d = fetch_wait_q;
        addr_x_d     = addr_x_q;
        addr_y_d     = addr_y_q;
        tx_start     = 1'b0;
        tx_byte      = 8'h00;
        tx_dc        = 1'b0;

        case (state_q)
            S_RES_HOLD: begin
                res_cnt_d = res_cnt_q + 32'd1;
                if (!res_phase_q) begin
                    if (res_cnt_q == RES_CYCLES) begin
                        res_n_d     = 1'b1;
                        res_phase_d = 1'b1;
                        res_cnt_d   = '0;
                    end
                end else if (res_cnt_q == RES_CYCLES - 1) begin
                    // First init byte launches on the last wait cycle.
                    tx_start  = 1'b1;
                    tx_byte   = init_byte(3'd0);
                    idx_d     = 3'd1;
                    res_cnt_d = '0;
                    state_d   = S_INIT;
                end
            end
            S_INIT: begin
                if (!tx_run_q) begin
                    if (idx_q == 3'd6) begin
                        idx_d   = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        tx_start = 1'b1;
                        tx_byte  = init_byte(idx_q);
                        idx_d    = idx_q + 3'd1;
                    end
                end
            end
            S_IDLE: begin
                if (start) begin
                    page_d  = 8'd0;
                    col_d   = 8'd0;
                    idx_d   = 3'd0;
                    state_d = S_PAGE_CMD;
                end
            end
            S_PAGE_CMD: begin
                if (!tx_run_q) begin
                    if (idx_q == 3'd3) begin
                        idx_d        = 3'd0;
                        addr_x_d     = col_q;
                        addr_y_d     = page_q;
                        fetch_wait_d = 1'b0;
                        state_d      = S_FETCH;
                    end else begin
                        tx_start = 1'b1;
                        case (idx_q)
                            3'd0:    tx_byte = 8'hB0 | page_q;
                            3'd1:    tx_byte = 8'h00;
                            default: tx_byte = 8'h10;
                        endcase
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_FETCH: begin
                // One cycle of memory read latency before ram_data is valid.
                if (!fetch_wait_q) begin
                    fetch_wait_d = 1'b1;
                end else begin
                    fetch_wait_d = 1'b0;
                    tx_start     = 1'b1;
                    tx_byte      = ram_data;
                    tx_dc        = 1'b1;
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                if (!tx_run_q) begin
                    if (col_q != LAST_COL) begin
                        col_d    = col_q + 8'd1;
                        addr_x_d = col_q + 8'd1;
                        addr_y_d = page_q;
                        state_d  = S_FETCH;
                    end else if (page_q != LAST_PAGE) begin
                        col_d   = 8'd0;
                        page_d  = page_q + 8'd1;
                        state_d = S_PAGE_CMD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
`ifdef FRAME_AUTO_EN
                page_d  = 8'd0;
                col_d   = 8'd0;
                idx_d   = 3'd0;
                state_d = S_PAGE_CMD;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_RES_HOLD;
        endcase
    end

    // SPI mode 0 byte engine: bit7 with cs_n fall, shift on each sclk fall.
    always_comb begin
        tx_run_d = tx_run_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        dc_d     = dc_q;

        if (tx_start) begin
            tx_run_d = 1'b1;
            cs_n_d   = 1'b0;
            sclk_d   = 1'b0;
            mosi_d   = tx_byte[7];
            shift_d  = tx_byte[6:0];
            dc_d     = tx_dc;
            div_d    = '0;
            bit_d    = 3'd0;
        end else if (tx_run_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        tx_run_d = 1'b0;
                        cs_n_d   = 1'b1;
                        mosi_d   = 1'b0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        mosi_d  = shift_q[6];
                        shift_d = {shift_q[5:0], 1'b0};
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_RES_HOLD;
            res_cnt_q    <= '0;
            res_phase_q  <= 1'b0;
            res_n_q      <= 1'b0;
            idx_q        <= 3'd0;
            page_q       <= 8'd0;
            col_q        <= 8'd0;
            fetch_wait_q <= 1'b0;
            addr_x_q     <= 8'd0;
            addr_y_q     <= 8'd0;
            tx_run_q     <= 1'b0;
            div_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 7'd0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            dc_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            res_cnt_q    <= res_cnt_d;
            res_phase_q  <= res_phase_d;
            res_n_q      <= res_n_d;
            idx_q        <= idx_d;
            page_q       <= page_d;
            col_q        <= col_d;
            fetch_wait_q <= fetch_wait_d;
            addr_x_q     <= addr_x_d;
            addr_y_q     <= addr_y_d;
            tx_run_q     <= tx_run_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            cs_n_q       <= cs_n_d;
            dc_q         <= dc_d;
        end
    end

    assign ram_addr_x = addr_x_q;
    assign ram_addr_y = addr_y_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign oled_sclk  = sclk_q;
    assign oled_mosi  = mosi_q;
    assign oled_cs_n  = cs_n_q;
    assign oled_dc    = dc_q;
    assign oled_res_n = res_n_q;

endmodule
`default_nettype wire

// File: tb/tb_oled_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_oled_frame_writer
// Brief    : Directed bench for oled_frame_writer with an SPI byte decoder and
//            a synchronous frame-memory model (byte = x ^ (y << 4)).
// Revision : 1.0 - initial release
// ============================================================================
module tb_oled_frame_writer;

`ifdef FRAME_AUTO_EN
    localparam int unsigned TB_DIV = 1;
`else
    localparam int unsigned TB_DIV = 2;
`endif
    localparam int unsigned TB_RES = 10;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic [7:0] ram_data = 8'h00;
    logic [7:0] ram_addr_x, ram_addr_y;
    logic       busy, frame_done;
    logic       oled_sclk, oled_mosi, oled_cs_n, oled_dc, oled_res_n;

    int checks = 0;
    int errors = 0;

    oled_frame_writer #(
        .CLK_DIV   (TB_DIV),
        .RES_CYCLES(TB_RES),
        .COLS      (132),
        .PAGES     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ram_addr_x(ram_addr_x),
        .ram_addr_y(ram_addr_y),
        .ram_data  (ram_data),
        .busy      (busy),
        .frame_done(frame_done),
        .oled_sclk (oled_sclk),
        .oled_mosi (oled_mosi),
        .oled_cs_n (oled_cs_n),
        .oled_dc   (oled_dc),
        .oled_res_n(oled_res_n)
    );

    always #5 clk = ~clk;

    // Memory returns the pattern between bytes and junk while a byte is on the wire.
    always @(posedge clk) begin
        ram_data <= oled_cs_n ? (ram_addr_x ^ (ram_addr_y << 4)) : 8'($urandom);
    end

    logic [8:0] mon_q[$];
    int         mon_bits  = 0;
    logic [7:0] mon_sh    = 8'h00;
    logic       mon_dc    = 1'b0;
    logic       prev_sclk = 1'b0;
    logic       prev_cs   = 1'b1;
    int         sclk_viol = 0;
    int         dc_viol   = 0;
    int         fd_cnt    = 0;
    int         busy_low  = 0;
    bit         track_busy = 1'b0;

    always @(negedge clk) begin
        if (oled_cs_n !== 1'b0) begin
            mon_bits = 0;
            if (oled_sclk === 1'b1) sclk_viol++;
        end else begin
            if (prev_cs) mon_dc = oled_dc;
            else if (oled_dc !== mon_dc) dc_viol++;
            if (oled_sclk && !prev_sclk) begin
                mon_sh = {mon_sh[6:0], oled_mosi};
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_q.push_back({mon_dc, mon_sh});
                    mon_bits = 0;
                end
            end
        end
        prev_sclk = oled_sclk;
        prev_cs   = oled_cs_n;
        if (frame_done === 1'b1) fd_cnt++;
        if (track_busy && busy !== 1'b1) busy_low++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic release_and_init(input string tag);
        int         n;
        logic [8:0] got;
        logic [7:0] init_exp[6];
        init_exp = '{8'hAE, 8'hA1, 8'hC8, 8'h81, 8'h80, 8'hAF};
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (oled_res_n === 1'b1) break;
            n++;
        end
        chk({tag, "_res_low_cycles"}, n, TB_RES);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (oled_cs_n === 1'b0) break;
        end
        chk({tag, "_first_cs_delay"}, n, TB_RES);
        chk({tag, "_init_dc"}, oled_dc, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            tick();
            n++;
        end
        chk({tag, "_busy_falls"}, busy, 0);
        chk({tag, "_init_count"}, mon_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            got = (i < mon_q.size()) ? mon_q[i] : 9'h1FF;
            chk($sformatf("%s_init%0d", tag, i), got, {1'b0, init_exp[i]});
        end
        repeat (60) tick();
        chk({tag, "_idle_no_queued_start"}, busy, 0);
        chk({tag, "_idle_no_bytes"}, mon_q.size(), 6);
        chk({tag, "_sclk_with_cs_high"}, sclk_viol, 0);
        chk({tag, "_dc_unstable"}, dc_viol, 0);
        mon_q.delete();
    endtask

    task automatic check_frame(input string tag);
        logic [8:0] got, exp;
        int         bad;
        chk({tag, "_bytes"}, mon_q.size(), 1080);
        for (int p = 0; p < 8; p++) begin
            bad = 0;
            for (int k = 0; k < 135; k++) begin
                if (k == 0)      exp = {1'b0, 8'hB0 | 8'(p)};
                else if (k == 1) exp = 9'h000;
                else if (k == 2) exp = 9'h010;
                else             exp = {1'b1, 8'(k - 3) ^ 8'(p << 4)};
                got = (mon_q.size() > 0) ? mon_q.pop_front() : 9'h1FF;
                if (got !== exp) bad++;
            end
            chk($sformatf("%s_page%0d_bad_bytes", tag, p), bad, 0);
        end
    endtask

    task automatic wait_done(input string tag, input bit idle_after);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 60000) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, frame_done, 1);
        chk({tag, "_busy_at_done"}, busy, 1);
        check_frame(tag);
        tick();
        chk({tag, "_done_one_cycle"}, frame_done, 0);
        chk({tag, "_busy_after_done"}, busy, idle_after ? 32'd0 : 32'd1);
    endtask

    initial begin
        int         n;
        int         fd_before;
        logic [8:0] got;

        repeat (3) tick();
        chk("rst_cs_n", oled_cs_n, 1);
        chk("rst_sclk", oled_sclk, 0);
        chk("rst_mosi", oled_mosi, 0);
        chk("rst_dc", oled_dc, 0);
        chk("rst_res_n", oled_res_n, 0);
        chk("rst_busy", busy, 1);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_addr", {ram_addr_y, ram_addr_x}, 0);

        release_and_init("por");

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
`ifndef FRAME_AUTO_EN
        repeat (3000) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5000) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("f1", 1'b1);
        repeat (100) tick();
        chk("f1_single_done", fd_cnt, 1);
        chk("f1_stays_idle", busy, 0);
        chk("f1_no_extra_bytes", mon_q.size(), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
`else
        track_busy = 1'b1;
        wait_done("f1", 1'b0);
        chk("f1_done_count", fd_cnt, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("f2", 1'b0);
        chk("f2_done_count", fd_cnt, 2);
        chk("auto_busy_never_low", busy_low, 0);
        track_busy = 1'b0;
`endif

        // Abort a byte partway through page 3.
        n = 0;
        while (mon_q.size() < 410 && n < 40000) begin
            tick();
            n++;
        end
        got = (mon_q.size() > 405) ? mon_q[405] : 9'h1FF;
        chk("mid_page3_cmd", got, 9'h0B3);
        n = 0;
        while (!(oled_cs_n === 1'b0 && oled_sclk === 1'b1) && n < 200) begin
            tick();
            n++;
        end
        chk("mid_in_byte", {oled_cs_n, oled_sclk}, 2'b01);
        fd_before = fd_cnt;
        rst = 1'b0;
        tick();
        chk("mid_rst_cs_n", oled_cs_n, 1);
        chk("mid_rst_sclk", oled_sclk, 0);
        chk("mid_rst_res_n", oled_res_n, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_addr", {ram_addr_y, ram_addr_x}, 0);
        tick();
        mon_q.delete();
        release_and_init("mid");
        chk("mid_no_frame_done", fd_cnt, fd_before);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
